// File: rtl/integ_ctrl_pkg.sv
// Shared control definitions for the integration-unit arbiters: state encoding
// and a round-robin pick function usable by any arbiter up to RR_MAXN requesters.
package integ_ctrl_pkg;

   localparam logic [1:0] ST_IDLE_C  = 2'd0;
   localparam logic [1:0] ST_ISSUE_C = 2'd1;
   localparam logic [1:0] ST_WAIT_C  = 2'd2;
   localparam logic [1:0] ST_DONE_C  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_IDLE_C,
      ST_ISSUE = ST_ISSUE_C,
      ST_WAIT  = ST_WAIT_C,
      ST_DONE  = ST_DONE_C
   } ctrl_state_e;

   localparam int RR_MAXN = 32;
   localparam int RR_IDXW = 5;
   localparam int RR_IDXP = RR_IDXW + 1;

   // First set request at or after ptr, wrapping at nreq; returns ptr when none is set.
   function automatic logic [RR_IDXW-1:0] rr_pick(input logic [RR_MAXN-1:0] req,
                                                  input logic [RR_IDXW-1:0] ptr,
                                                  input int nreq);
      logic [RR_IDXW-1:0] pick;
      logic [RR_IDXP-1:0] idx;
      logic               found;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < RR_MAXN; k++) begin
         idx = {1'b0, ptr} + RR_IDXP'(k);
         if (idx >= RR_IDXP'(nreq)) idx = idx - RR_IDXP'(nreq);
         if ((k < nreq) && !found && req[idx[RR_IDXW-1:0]]) begin
            pick  = idx[RR_IDXW-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/integ_unit_sched_if.sv
// Requester-side bundle of the shared integration-unit scheduler.
interface integ_unit_sched_if #(
   parameter int NREQ = 4,
   parameter int SELW = (NREQ > 1) ? $clog2(NREQ) : 1
);

   logic [NREQ-1:0] req;
   logic            flush;
   logic [NREQ-1:0] gnt;
   logic [SELW-1:0] sel;
   logic            unit_start;
   logic [NREQ-1:0] done;
   logic            busy;

   modport master (
      output req, flush,
      input  gnt, sel, unit_start, done, busy
   );

   modport slave (
      input  req, flush,
      output gnt, sel, unit_start, done, busy
   );

endinterface

// File: rtl/op_latency_timer.sv
// One-hot shift-register timer: load places a single bit at LAT-1, which walks
// down to bit 0 over LAT-1 clocks; expire reflects bit 0.
module op_latency_timer #(
   parameter int LAT = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic clear,
   output logic expire
);

   logic [LAT-1:0] timer_q;
   logic [LAT-1:0] timer_d;

   always_comb begin
      timer_d = timer_q >> 1;
      if (clear) begin
         timer_d = '0;
      end else if (load) begin
         timer_d          = '0;
         timer_d[LAT-1]   = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign expire = timer_q[0];

endmodule

// File: rtl/integ_unit_sched.sv
// Round-robin scheduler sharing one fixed-latency integration arithmetic unit
// among NREQ requesters; every output is registered from the next-state decode.
module integ_unit_sched
   import integ_ctrl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int LAT  = 3,
   parameter int SELW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clock,
   input  logic              reset,
   integ_unit_sched_if.slave bus
);

   ctrl_state_e     state_q, state_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [SELW-1:0] owner_q, owner_d;
   logic [SELW-1:0] ptr_inc;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic            start_q, start_d;
   logic            busy_q, busy_d;

   logic [RR_MAXN-1:0] req_wide;
   logic [RR_IDXW-1:0] pick_idle;
   logic [RR_IDXW-1:0] pick_done;
   logic               any_req;
   logic               timer_load;
   logic               timer_clear;
   logic               timer_expire;

   assign req_wide = RR_MAXN'(bus.req);
   assign any_req  = |bus.req;
   assign ptr_inc  = (owner_q == SELW'(NREQ - 1)) ? '0 : owner_q + SELW'(1);

   // DONE re-arbitrates from the pointer it is about to commit, not the stale one.
   assign pick_idle = rr_pick(req_wide, RR_IDXW'(ptr_q), NREQ);
   assign pick_done = rr_pick(req_wide, RR_IDXW'(ptr_inc), NREQ);

   op_latency_timer #(
      .LAT (LAT)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .load   (timer_load),
      .clear  (timer_clear),
      .expire (timer_expire)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      timer_clear = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d = SELW'(pick_idle);
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE, ST_WAIT: begin
            if (bus.flush) begin
               state_d     = ST_IDLE;
               timer_clear = 1'b1;
            end else if (timer_expire) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            ptr_d = ptr_inc;
            if (any_req && !bus.flush) begin
               owner_d = SELW'(pick_done);
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign timer_load = (state_d == ST_ISSUE);

   always_comb begin
      gnt_d   = '0;
      done_d  = '0;
      sel_d   = '0;
      start_d = 1'b0;
      busy_d  = (state_d != ST_IDLE);
      if (state_d != ST_IDLE) begin
         sel_d = owner_d;
      end
      if (state_d == ST_ISSUE) begin
         gnt_d[owner_d] = 1'b1;
         start_d        = 1'b1;
      end
      if (state_d == ST_DONE) begin
         done_d[owner_d] = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         sel_q   <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         sel_q   <= sel_d;
         start_q <= start_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.done       = done_q;
   assign bus.sel        = sel_q;
   assign bus.unit_start = start_q;
   assign bus.busy       = busy_q;

endmodule
